// File: rtl/upcount_modload_if.sv
// Bus bundle for upcount_modload: control/data inputs, count and status outputs.
// master drives the controls (testbench/parent); slave is the counter itself.
interface upcount_modload_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] modval;
   logic             clr_ovf;
   logic [WIDTH-1:0] out;
   logic             co;
   logic             tc;
   logic             ovf;

   modport master (
      output en, load, din, modval, clr_ovf,
      input  out, co, tc, ovf
   );

   modport slave (
      input  en, load, din, modval, clr_ovf,
      output out, co, tc, ovf
   );
endinterface

// File: rtl/upcount_modload.sv
// Loadable up-counter that wraps to 0 after a runtime terminal value (modval).
// Optional sticky out-of-range wrap flag enabled by macro UPCOUNT_MODLOAD_OVF_EN.
module upcount_modload #(
   parameter int unsigned WIDTH = 4
) (
   input logic               clk,
   input logic               reset,
   upcount_modload_if.slave  bus
);
   logic [WIDTH-1:0] count;
   logic             tc_q;
   logic             at_mod;
   logic             advance;

   // modval is compared live every cycle, never latched
   assign at_mod  = (count == bus.modval);
   assign advance = bus.en & ~bus.load;

   assign bus.out = count;
   assign bus.tc  = tc_q;
   assign bus.co  = advance & at_mod;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tc_q  <= 1'b0;
      end else if (bus.load) begin
         count <= bus.din;
         tc_q  <= 1'b0;
      end else if (bus.en) begin
         if (at_mod) begin
            count <= '0;
            tc_q  <= 1'b1;
         end else begin
            // above modval this rolls over modulo 2^WIDTH
            count <= count + WIDTH'(1);
            tc_q  <= 1'b0;
         end
      end else begin
         tc_q <= 1'b0;
      end
   end

`ifdef UPCOUNT_MODLOAD_OVF_EN
   logic ovf_q;
   logic set_ovf;

   // all-ones rollover while not at modval means we were out of range
   assign set_ovf = advance & ~at_mod & (count == {WIDTH{1'b1}});
   assign bus.ovf = ovf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (set_ovf) begin
         ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_q <= 1'b0;
      end
   end
`else
   logic unused_clr_ovf;

   assign unused_clr_ovf = bus.clr_ovf;
   assign bus.ovf        = 1'b0;
`endif
endmodule

// File: tb/tb_upcount_modload.sv
// Directed self-checking bench for upcount_modload (WIDTH=4).
// ovf expectations follow UPCOUNT_MODLOAD_OVF_EN when it is defined for the build.
module tb_upcount_modload;
   localparam int unsigned WIDTH = 4;
`ifdef UPCOUNT_MODLOAD_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   upcount_modload_if #(.WIDTH(WIDTH)) bus ();

   upcount_modload #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] o, input logic t, input logic v);
      check({tag, ".out"}, 16'(bus.out), 16'(o));
      check({tag, ".tc"},  16'(bus.tc),  16'(t));
      check({tag, ".ovf"}, 16'(bus.ovf), 16'(v));
   endtask

   initial begin
      logic [3:0] seq_out [8];
      logic       seq_tc  [8];
      seq_out = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2};
      seq_tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      checks = 0;
      errors = 0;

      // Reset with load/en active: must be ignored
      reset       = 1'b0;
      bus.en      = 1'b1;
      bus.load    = 1'b1;
      bus.din     = 4'd7;
      bus.modval  = 4'd5;
      bus.clr_ovf = 1'b0;
      #2 reset = 1'b1;
      #1 check_all("reset_async", 4'd0, 1'b0, 1'b0);
      tick();
      tick();
      check_all("reset_held", 4'd0, 1'b0, 1'b0);
      bus.load = 1'b0;
      bus.en   = 1'b0;
      reset    = 1'b0;
      tick();
      check_all("post_reset_idle", 4'd0, 1'b0, 1'b0);

      // Modulo-6 count: 1,2,3,4,5,0,1,2
      bus.en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("co_pre", 16'(bus.co), (i == 5) ? 16'd1 : 16'd0);
         tick();
         check_all("mod5_seq", seq_out[i], seq_tc[i], 1'b0);
      end
      tick();
      check("mod5_to3", 16'(bus.out), 16'd3);

      // Load wins over en
      bus.load = 1'b1;
      bus.din  = 4'd9;
      #1 check("co_during_load", 16'(bus.co), 16'd0);
      tick();
      check_all("load9", 4'd9, 1'b0, 1'b0);
      bus.load = 1'b0;
      bus.en   = 1'b0;
      tick();
      check_all("idle_hold", 4'd9, 1'b0, 1'b0);

      // Out-of-range: 14,15,0,1 with ovf set on rollover
      bus.load = 1'b1;
      bus.din  = 4'd14;
      tick();
      check_all("load14", 4'd14, 1'b0, 1'b0);
      bus.load = 1'b0;
      bus.en   = 1'b1;
      tick();
      check_all("oor15", 4'd15, 1'b0, 1'b0);
      tick();
      check_all("oor0", 4'd0, 1'b0, OVF_ON);
      tick();
      check_all("oor1", 4'd1, 1'b0, OVF_ON);
      bus.en      = 1'b0;
      bus.clr_ovf = 1'b1;
      tick();
      check_all("clr_ovf", 4'd1, 1'b0, 1'b0);
      bus.clr_ovf = 1'b0;

      // Set beats clear in the same cycle
      bus.load = 1'b1;
      bus.din  = 4'd15;
      tick();
      bus.load    = 1'b0;
      bus.en      = 1'b1;
      bus.clr_ovf = 1'b1;
      tick();
      check_all("set_wins", 4'd0, 1'b0, OVF_ON);
      bus.en = 1'b0;
      tick();
      check_all("clr_after", 4'd0, 1'b0, 1'b0);
      bus.clr_ovf = 1'b0;

      // modval all-ones: wrap gives tc, not ovf
      bus.modval = 4'd15;
      bus.load   = 1'b1;
      bus.din    = 4'd14;
      tick();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      tick();
      check_all("full15", 4'd15, 1'b0, 1'b0);
      tick();
      check_all("full_wrap", 4'd0, 1'b1, 1'b0);

      // modval = 0: stuck at 0 with tc every cycle
      bus.modval = 4'd0;
      #1 check("co_mod0", 16'(bus.co), 16'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("mod0", 4'd0, 1'b1, 1'b0);
         check("co_mod0_loop", 16'(bus.co), 16'd1);
      end

      // Live modval change: count to 2, then lower modval to 1
      bus.modval = 4'd2;
      tick();
      check_all("mv_1", 4'd1, 1'b0, 1'b0);
      tick();
      check_all("mv_2", 4'd2, 1'b0, 1'b0);
      bus.modval = 4'd1;
      tick();
      check_all("mv_above", 4'd3, 1'b0, 1'b0);

      // Async reset mid-count at out=4
      bus.modval = 4'd5;
      bus.en     = 1'b0;
      bus.load   = 1'b1;
      bus.din    = 4'd4;
      tick();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      check("pre_rst4", 16'(bus.out), 16'd4);
      #2 reset = 1'b1;
      #1 check_all("rst_mid", 4'd0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      check_all("rst_held_edge", 4'd0, 1'b0, 1'b0);
      tick();
      check_all("restart1", 4'd1, 1'b0, 1'b0);
      tick();
      check_all("restart2", 4'd2, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/upcount_modload.md
UPCOUNT_MODLOAD -- requirements
Module: upcount_modload

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..16).
REQ-002 clk  input  1  Sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 en  input  1  Count enable; high means advance by one this cycle.
REQ-005 load  input  1  Synchronous parallel load strobe.
REQ-006 din  input  WIDTH  Parallel load value.
REQ-007 modval  input  WIDTH  Terminal value; the count wraps to 0 after this value.
REQ-008 clr_ovf  input  1  Synchronous clear of the sticky out-of-range flag.
REQ-009 out  output  WIDTH  Registered count value.
REQ-010 co  output  1  Combinational carry-out for cascading: en & ~load & (out == modval).
REQ-011 tc  output  1  Registered terminal-count pulse.
REQ-012 ovf  output  1  Registered sticky out-of-range wrap flag.

Function
REQ-013 Per-cycle priority SHALL be: reset, then load, then en; with none asserted all registers hold.
REQ-014 On load=1, out SHALL take din at the next edge, regardless of en, din value or modval.
REQ-015 On load=0, en=1 and out == modval, out SHALL become 0 and tc SHALL be 1 in the following cycle.
REQ-016 On load=0, en=1 and out < modval, out SHALL become out+1 and tc SHALL be 0.
REQ-017 On load=0, en=1 and out > modval (reachable only by load or a modval change):
 - out SHALL increment modulo 2^WIDTH;
 - on the all-ones to 0 transition, ovf SHALL set and tc SHALL stay 0.
REQ-018 tc SHALL be a one-cycle pulse, 0 on every cycle not immediately following a REQ-015 wrap, including load cycles and idle cycles.
REQ-019 modval SHALL be sampled every cycle; a change takes effect on the next comparison, with no internal latching.
REQ-020 When modval = 0 and en is held, out SHALL stay 0 and tc SHALL be 1 on every cycle after the first enabled edge.
REQ-021 When modval = all-ones, the counter SHALL behave as a free-running modulo-2^WIDTH counter; the wrap asserts tc, not ovf.
REQ-022 clr_ovf=1 SHALL clear ovf at the next edge; if a set event (REQ-017) occurs in the same cycle, set SHALL win.
REQ-023 Counting latency SHALL be one clock from en to the out update; co SHALL have zero latency.

Reset
REQ-024 While reset=1, out SHALL be 0, tc SHALL be 0 and ovf SHALL be 0, asynchronously and independent of clk.
REQ-025 Deassertion of reset mid-count SHALL resume operation from out=0 on the first rising edge with reset low.
REQ-026 A load or en asserted during reset SHALL be ignored, with no post-reset effect.

Configuration
REQ-027 Macro UPCOUNT_MODLOAD_OVF_EN SHALL control the out-of-range tracking logic.
 - Defined: ovf and clr_ovf SHALL behave per REQ-017 and REQ-022.
 - Undefined: ovf SHALL be tied to 0, clr_ovf SHALL be ignored, and no ovf register SHALL be synthesized. Counting per REQ-017 SHALL be unchanged.

Verification
REQ-028 Apply reset, then modval=5, en=1 for 8 cycles.
 -> out = 1,2,3,4,5,0,1,2; tc=1 only in the cycle out first reads 0.
REQ-029 At out=3, pulse load=1 with en=1 and din=9.
 -> out=9 next cycle; no tc pulse.
REQ-030 Load din=14 with WIDTH=4, modval=5, then apply en.
 -> out = 14,15,0,1; ovf=1 from the cycle out=0; tc stays 0.
 -> clr_ovf then clears ovf. With the macro undefined, ovf stays 0 throughout.
REQ-031 Assert reset asynchronously between edges while out=4, en=1.
 -> out, tc and ovf read 0 immediately; after release the count restarts 1,2,...
REQ-032 Raise clr_ovf=1 in the same cycle as a 15->0 out-of-range wrap.
 -> ovf=1 after the edge.
REQ-033 Set modval=0, en=1.
 -> out holds 0, tc=1 every cycle, co=1 combinationally.
